// File: rtl/mmio_timer_core_pkg.sv
// Shared types and register map for the slot-0 MMIO timer.
package mmio_timer_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_COMMIT,
        ST_WR_DONE,
        ST_RD_DONE
    } timer_state_t;

    localparam logic [7:0] TIMER_CTRL   = 8'h00;
    localparam logic [7:0] TIMER_CNT_LO = 8'h04;
    localparam logic [7:0] TIMER_CNT_HI = 8'h08;
    localparam logic [7:0] TIMER_CMP_LO = 8'h0C;
    localparam logic [7:0] TIMER_CMP_HI = 8'h10;
    localparam logic [7:0] TIMER_STATUS = 8'h14;
    localparam logic [7:0] TIMER_PRESC  = 8'h18;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_CLR         = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_AUTO_RELOAD = 3;

    typedef struct packed {
        logic slave_err;
        logic decode_err;
    } access_err_t;

    // Classifies an access: misaligned or unmapped offsets are decode errors,
    // writes to the read-only counter words are slave errors.
    function automatic access_err_t decode_access(input logic [7:0] addr, input logic is_write);
        access_err_t err;
        err = '0;
        if (addr[1:0] != 2'b00) begin
            err.decode_err = 1'b1;
        end else begin
            case (addr)
                TIMER_CTRL, TIMER_CMP_LO, TIMER_CMP_HI, TIMER_STATUS, TIMER_PRESC: ;
                TIMER_CNT_LO, TIMER_CNT_HI: err.slave_err = is_write;
                default: err.decode_err = 1'b1;
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/mmio_timer_core_if.sv
// Slot interface between the AXI4-Lite MMIO controller and one slot device.
interface mmio_timer_core_if;

    logic        cs;
    logic        read;
    logic        write;
    logic [7:0]  reg_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        wr_done;
    logic        rd_done;
    logic        idle;
    logic        slave_error;
    logic        decode_error;

    modport master (
        output cs, read, write, reg_addr, wr_data,
        input  rd_data, wr_done, rd_done, idle, slave_error, decode_error
    );

    modport slave (
        input  cs, read, write, reg_addr, wr_data,
        output rd_data, wr_done, rd_done, idle, slave_error, decode_error
    );

endinterface

// File: rtl/mmio_timer_core_counter.sv
// Prescaler, 64-bit free-running counter and compare/match flag.
module mmio_timer_counter #(
    parameter int PRESC_W = 16
) (
    input  logic               aclk,
    input  logic               arst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               auto_reload,
    input  logic               match_clr,
    input  logic [PRESC_W-1:0] presc,
    input  logic [63:0]        cmp,
    output logic [63:0]        count,
    output logic               match
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic               hit;

    assign tick = en && (presc_cnt == presc);
    assign hit  = tick && (count == cmp);

    // Prescaler runs 0..presc while enabled; clr restarts it from zero.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            presc_cnt <= '0;
        end else if (clr) begin
            presc_cnt <= '0;
        end else if (en) begin
            if (presc_cnt == presc) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

    // Counter advances on each prescaler wrap; a match with auto_reload restarts it.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (hit && auto_reload) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 64'd1;
        end
    end

    // Sticky match flag; a fresh match beats a simultaneous write-one-to-clear.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (match_clr) begin
            match <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_timer_core.sv
// Slot-0 MMIO timer: access FSM and register file around the counter sub-module.
module mmio_timer_core
    import mmio_timer_core_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic               aclk,
    input  logic               arst_n,
    mmio_timer_core_if.slave   bus,
    output logic               irq
);

    timer_state_t       state;
    timer_state_t       next_state;
    logic [7:0]         addr_q;
    logic               ctrl_en;
    logic               ctrl_irq_en;
    logic               ctrl_auto_reload;
    logic [63:0]        cmp;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        shadow;
    logic [31:0]        rd_data_q;
    logic               slave_err_q;
    logic               decode_err_q;
    logic [63:0]        count;
    logic               match;

    logic               accept_wr;
    logic               accept_rd;
    logic               commit_ok;
    logic               clr_pulse;
    logic               match_clr;
    access_err_t        wr_err;
    access_err_t        rd_err;
    logic [31:0]        rd_mux;
    logic               wr_done_s;
    logic               rd_done_s;
    logic               idle_s;

    assign accept_wr = (state == ST_IDLE) && bus.cs && bus.write;
    assign accept_rd = (state == ST_IDLE) && bus.cs && bus.read && !bus.write;
    assign wr_err    = decode_access(addr_q, 1'b1);
    assign rd_err    = decode_access(bus.reg_addr, 1'b0);
    assign commit_ok = (state == ST_WR_COMMIT) && !wr_err.slave_err && !wr_err.decode_err;
    assign clr_pulse = commit_ok && (addr_q == TIMER_CTRL) && bus.wr_data[CTRL_CLR];
    assign match_clr = commit_ok && (addr_q == TIMER_STATUS) && bus.wr_data[0];
    assign irq       = match && ctrl_irq_en;

    mmio_timer_counter #(.PRESC_W(PRESC_W)) u_counter (
        .aclk        (aclk),
        .arst_n      (arst_n),
        .en          (ctrl_en),
        .clr         (clr_pulse),
        .auto_reload (ctrl_auto_reload),
        .match_clr   (match_clr),
        .presc       (presc),
        .cmp         (cmp),
        .count       (count),
        .match       (match)
    );

    // State register; reset aborts any transaction back to IDLE.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a write wins when both strobes arrive together.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.cs && bus.write) begin
                    next_state = ST_WR_COMMIT;
                end else if (bus.cs && bus.read) begin
                    next_state = ST_RD_DONE;
                end
            end
            ST_WR_COMMIT: next_state = ST_WR_DONE;
            ST_WR_DONE: begin
                if (!bus.write) begin
                    next_state = ST_IDLE;
                end
            end
            ST_RD_DONE: begin
                if (!(bus.cs && bus.read)) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        wr_done_s = 1'b0;
        rd_done_s = 1'b0;
        idle_s    = 1'b0;
        case (state)
            ST_IDLE:    idle_s    = 1'b1;
            ST_WR_DONE: wr_done_s = 1'b1;
            ST_RD_DONE: rd_done_s = 1'b1;
            default:    ;
        endcase
    end

    assign bus.wr_done      = wr_done_s;
    assign bus.rd_done      = rd_done_s;
    assign bus.idle         = idle_s;
    assign bus.rd_data      = rd_data_q;
    assign bus.slave_error  = slave_err_q;
    assign bus.decode_error = decode_err_q;

    // Read multiplexer on the live address; clr always reads back as zero.
    always_comb begin
        rd_mux = '0;
        case (bus.reg_addr)
            TIMER_CTRL:   rd_mux = {28'd0, ctrl_auto_reload, ctrl_irq_en, 1'b0, ctrl_en};
            TIMER_CNT_LO: rd_mux = count[31:0];
            TIMER_CNT_HI: rd_mux = shadow;
            TIMER_CMP_LO: rd_mux = cmp[31:0];
            TIMER_CMP_HI: rd_mux = cmp[63:32];
            TIMER_STATUS: rd_mux = {31'd0, match};
            TIMER_PRESC:  rd_mux = 32'(presc);
            default:      rd_mux = '0;
        endcase
    end

    // Write address is latched on accept so the data phase can follow a cycle later.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            addr_q <= '0;
        end else if (accept_wr) begin
            addr_q <= bus.reg_addr;
        end
    end

    // Read data and error status stay put until the next access is accepted.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            rd_data_q    <= '0;
            slave_err_q  <= 1'b0;
            decode_err_q <= 1'b0;
            shadow       <= '0;
        end else if (accept_wr) begin
            slave_err_q  <= 1'b0;
            decode_err_q <= 1'b0;
        end else if (accept_rd) begin
            rd_data_q    <= rd_mux;
            slave_err_q  <= rd_err.slave_err;
            decode_err_q <= rd_err.decode_err;
            if (bus.reg_addr == TIMER_CNT_LO) begin
                shadow <= count[63:32];
            end
        end else if (state == ST_WR_COMMIT) begin
            slave_err_q  <= wr_err.slave_err;
            decode_err_q <= wr_err.decode_err;
        end
    end

    // Configuration registers are updated only by an error-free write commit.
    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            ctrl_en          <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            cmp              <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc            <= '0;
        end else if (commit_ok) begin
            case (addr_q)
                TIMER_CTRL: begin
                    ctrl_en          <= bus.wr_data[CTRL_EN];
                    ctrl_irq_en      <= bus.wr_data[CTRL_IRQ_EN];
                    ctrl_auto_reload <= bus.wr_data[CTRL_AUTO_RELOAD];
                end
                TIMER_CMP_LO: cmp[31:0]  <= bus.wr_data;
                TIMER_CMP_HI: cmp[63:32] <= bus.wr_data;
                TIMER_PRESC:  presc      <= bus.wr_data[PRESC_W-1:0];
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer_core.sv
// Directed self-checking bench for the slot-0 MMIO timer.
module tb_mmio_timer_core;
    import mmio_timer_core_pkg::*;

    logic        aclk;
    logic        arst_n;
    logic        irq;
    logic [31:0] rdata;
    int          checks;
    int          failures;

    mmio_timer_core_if bus_if ();

    mmio_timer_core #(.PRESC_W(16)) dut (
        .aclk   (aclk),
        .arst_n (arst_n),
        .bus    (bus_if),
        .irq    (irq)
    );

    // Free-running 100 MHz clock.
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Counts one comparison and reports it when it disagrees.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete bus access, starting and ending just after a falling edge.
    task automatic applyStimulus(input logic is_write, input logic [7:0] addr,
                                 input logic [31:0] data, output logic [31:0] rd);
        bus_if.cs       = 1'b1;
        bus_if.write    = is_write;
        bus_if.read     = !is_write;
        bus_if.reg_addr = addr;
        @(negedge aclk);
        if (is_write) begin
            bus_if.cs      = 1'b0;
            bus_if.wr_data = data;
            @(negedge aclk);
            checkOutput("wr_done_latency", {63'd0, bus_if.wr_done}, 64'd1);
            bus_if.write = 1'b0;
        end else begin
            checkOutput("rd_done_latency", {63'd0, bus_if.rd_done}, 64'd1);
            bus_if.cs   = 1'b0;
            bus_if.read = 1'b0;
        end
        rd = bus_if.rd_data;
        @(negedge aclk);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        arst_n          = 1'b0;
        bus_if.cs       = 1'b0;
        bus_if.read     = 1'b0;
        bus_if.write    = 1'b0;
        bus_if.reg_addr = '0;
        bus_if.wr_data  = '0;
        repeat (3) @(negedge aclk);

        checkOutput("rst_idle", {63'd0, bus_if.idle}, 64'd1);
        checkOutput("rst_rd_data", {32'd0, bus_if.rd_data}, 64'd0);
        checkOutput("rst_irq", {63'd0, irq}, 64'd0);
        checkOutput("rst_wr_done", {63'd0, bus_if.wr_done}, 64'd0);
        checkOutput("rst_rd_done", {63'd0, bus_if.rd_done}, 64'd0);
        checkOutput("rst_errors", {62'd0, bus_if.slave_error, bus_if.decode_error}, 64'd0);
        arst_n = 1'b1;
        @(negedge aclk);

        applyStimulus(1'b0, TIMER_STATUS, 32'd0, rdata);
        checkOutput("status_reset", {32'd0, rdata}, 64'd0);
        checkOutput("status_no_err", {62'd0, bus_if.slave_error, bus_if.decode_error}, 64'd0);
        applyStimulus(1'b0, TIMER_CMP_LO, 32'd0, rdata);
        checkOutput("cmp_lo_reset", {32'd0, rdata}, 64'hFFFF_FFFF);

        applyStimulus(1'b1, TIMER_CTRL, 32'hE, rdata);
        applyStimulus(1'b0, TIMER_CTRL, 32'd0, rdata);
        checkOutput("ctrl_clr_reads_0", {32'd0, rdata}, 64'hC);
        applyStimulus(1'b1, TIMER_PRESC, 32'h0001_2345, rdata);
        applyStimulus(1'b0, TIMER_PRESC, 32'd0, rdata);
        checkOutput("presc_width", {32'd0, rdata}, 64'h2345);

        // Divide-by-4: count is cleared at the CTRL commit, then steps every 4 cycles.
        applyStimulus(1'b1, TIMER_PRESC, 32'd3, rdata);
        applyStimulus(1'b1, TIMER_CTRL, 32'h3, rdata);
        applyStimulus(1'b0, TIMER_CNT_LO, 32'd0, rdata);
        checkOutput("cnt_presc_t2", {32'd0, rdata}, 64'd0);
        repeat (38) @(negedge aclk);
        applyStimulus(1'b0, TIMER_CNT_LO, 32'd0, rdata);
        checkOutput("cnt_presc_t42", {32'd0, rdata}, 64'd10);
        repeat (2) @(negedge aclk);
        applyStimulus(1'b0, TIMER_CNT_LO, 32'd0, rdata);
        checkOutput("cnt_presc_t46", {32'd0, rdata}, 64'd11);
        applyStimulus(1'b0, TIMER_CNT_HI, 32'd0, rdata);
        checkOutput("cnt_hi_shadow", {32'd0, rdata}, 64'd0);

        // Compare at 10 with auto-reload: match lands on the 11th tick after enable.
        applyStimulus(1'b1, TIMER_CTRL, 32'h2, rdata);
        applyStimulus(1'b1, TIMER_PRESC, 32'd0, rdata);
        applyStimulus(1'b1, TIMER_CMP_LO, 32'd10, rdata);
        applyStimulus(1'b1, TIMER_CMP_HI, 32'd0, rdata);
        applyStimulus(1'b1, TIMER_CTRL, 32'hD, rdata);
        repeat (9) @(negedge aclk);
        checkOutput("irq_before_match", {63'd0, irq}, 64'd0);
        @(negedge aclk);
        checkOutput("irq_at_match", {63'd0, irq}, 64'd1);
        applyStimulus(1'b0, TIMER_CNT_LO, 32'd0, rdata);
        checkOutput("cnt_auto_reload", {32'd0, rdata}, 64'd0);
        applyStimulus(1'b1, TIMER_STATUS, 32'd1, rdata);
        checkOutput("irq_after_w1c", {63'd0, irq}, 64'd0);
        applyStimulus(1'b0, TIMER_STATUS, 32'd0, rdata);
        checkOutput("status_after_w1c", {32'd0, rdata}, 64'd0);
        repeat (2) @(negedge aclk);
        applyStimulus(1'b1, TIMER_STATUS, 32'd1, rdata);
        checkOutput("irq_set_beats_w1c", {63'd0, irq}, 64'd1);
        applyStimulus(1'b0, TIMER_STATUS, 32'd0, rdata);
        checkOutput("status_set_beats_w1c", {32'd0, rdata}, 64'd1);

        // Freeze at a known count, then poke the read-only counter word.
        applyStimulus(1'b1, TIMER_CTRL, 32'h2, rdata);
        applyStimulus(1'b1, TIMER_STATUS, 32'd1, rdata);
        checkOutput("irq_cleared", {63'd0, irq}, 64'd0);
        applyStimulus(1'b1, TIMER_CTRL, 32'h1, rdata);
        applyStimulus(1'b1, TIMER_CTRL, 32'h0, rdata);
        applyStimulus(1'b0, TIMER_CNT_LO, 32'd0, rdata);
        checkOutput("cnt_frozen", {32'd0, rdata}, 64'd3);
        applyStimulus(1'b1, TIMER_CNT_LO, 32'hFFFF_FFFF, rdata);
        checkOutput("wr_ro_slave_err", {63'd0, bus_if.slave_error}, 64'd1);
        checkOutput("wr_ro_no_decode", {63'd0, bus_if.decode_error}, 64'd0);
        checkOutput("rd_data_held", {32'd0, rdata}, 64'd3);
        applyStimulus(1'b0, TIMER_CNT_LO, 32'd0, rdata);
        checkOutput("cnt_after_ro_wr", {32'd0, rdata}, 64'd3);
        checkOutput("err_cleared", {62'd0, bus_if.slave_error, bus_if.decode_error}, 64'd0);

        applyStimulus(1'b0, 8'h1C, 32'd0, rdata);
        checkOutput("rd_unmapped", {62'd0, bus_if.slave_error, bus_if.decode_error}, 64'd1);
        applyStimulus(1'b0, 8'h02, 32'd0, rdata);
        checkOutput("rd_misaligned", {62'd0, bus_if.slave_error, bus_if.decode_error}, 64'd1);
        applyStimulus(1'b1, 8'h20, 32'd5, rdata);
        checkOutput("wr_unmapped", {62'd0, bus_if.slave_error, bus_if.decode_error}, 64'd1);

        // Reset asserted while the write sits in WR_COMMIT.
        bus_if.cs       = 1'b1;
        bus_if.write    = 1'b1;
        bus_if.reg_addr = TIMER_CMP_LO;
        @(negedge aclk);
        bus_if.cs      = 1'b0;
        bus_if.wr_data = 32'd5;
        #2 arst_n = 1'b0;
        bus_if.write = 1'b0;
        @(negedge aclk);
        checkOutput("rst_mid_idle", {63'd0, bus_if.idle}, 64'd1);
        arst_n = 1'b1;
        @(negedge aclk);
        checkOutput("post_rst_idle", {63'd0, bus_if.idle}, 64'd1);
        applyStimulus(1'b0, TIMER_CMP_LO, 32'd0, rdata);
        checkOutput("post_rst_cmp_lo", {32'd0, rdata}, 64'hFFFF_FFFF);
        applyStimulus(1'b0, TIMER_CMP_HI, 32'd0, rdata);
        checkOutput("post_rst_cmp_hi", {32'd0, rdata}, 64'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
